// File: rtl/gba_noise_gen_if.sv
// Decoded register bus between the sound register wrapper and the noise channel.
// The wrapper is the master; the noise channel is the slave.
interface gba_noise_gen_if #(
    parameter int LEN_W = 6,
    parameter int OUT_W = 16
);
    logic                    en;
    logic                    wr_len;
    logic [LEN_W-1:0]        len_val;
    logic                    wr_env;
    logic [3:0]              init_vol;
    logic                    env_dir;
    logic [2:0]              env_step;
    logic                    wr_ctl;
    logic [2:0]              div_ratio;
    logic [3:0]              shift;
    logic                    short_mode;
    logic                    len_en;
    logic                    trigger;
    logic signed [OUT_W-1:0] sample_out;
    logic                    ch_on;
    logic [LEN_W:0]          len_left;

    modport master (
        output en, wr_len, len_val, wr_env, init_vol, env_dir, env_step,
        output wr_ctl, div_ratio, shift, short_mode, len_en, trigger,
        input  sample_out, ch_on, len_left
    );

    modport slave (
        input  en, wr_len, len_val, wr_env, init_vol, env_dir, env_step,
        input  wr_ctl, div_ratio, shift, short_mode, len_en, trigger,
        output sample_out, ch_on, len_left
    );
endinterface

// File: rtl/gba_noise_gen.sv
// White-noise sound channel: LFSR noise scaled by a 4-bit envelope volume,
// gated by a length counter, DAC-off detection and a frozen-LFSR mode.
module gba_noise_gen #(
    parameter int LFSR_W     = 15,
    parameter int SHORT_W    = 7,
    parameter int LEN_W      = 6,
    parameter int DIV_W      = 24,
    parameter int OUT_W      = 16,
    parameter int ENV_PERIOD = 65536,
    parameter int LEN_PERIOD = 16384
) (
    input logic              clk,
    input logic              reset,
    gba_noise_gen_if.slave   bus
);
    localparam int EW = (ENV_PERIOD > 2) ? $clog2(ENV_PERIOD) : 1;
    localparam int LW = (LEN_PERIOD > 2) ? $clog2(LEN_PERIOD) : 1;
    localparam logic [LEN_W:0] LEN_MAX = {1'b1, {LEN_W{1'b0}}};

    logic              clr;
    logic [EW-1:0]     env_cnt_q, env_cnt_d;
    logic [LW-1:0]     len_cnt_q, len_cnt_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_nx;
    logic [DIV_W-1:0]  freq_cnt_q, freq_cnt_d;
    logic [DIV_W-1:0]  period_q, period_d, base;
    logic              freeze_q, freeze_d;
    logic              short_q, short_d;
    logic              len_en_q, len_en_d;
    logic [3:0]        iv_q, iv_d;
    logic              dir_q, dir_d;
    logic [2:0]        estep_q, estep_d;
    logic [2:0]        scnt_q, scnt_d;
    logic              done_q, done_d;
    logic [3:0]        vol_q, vol_d;
    logic [LEN_W:0]    len_q, len_d, len_base;
    logic              on_q, on_d;
    logic [OUT_W-1:0]  smp_q, smp_d, mag;
    logic              env_tick, len_tick, fb;

    assign clr = reset | ~bus.en;

    // Next-state: frame counters, LFSR clock, envelope, length and register writes
    always_comb begin
        env_cnt_d  = env_cnt_q;
        len_cnt_d  = len_cnt_q;
        lfsr_d     = lfsr_q;
        freq_cnt_d = freq_cnt_q;
        period_d   = period_q;
        freeze_d   = freeze_q;
        short_d    = short_q;
        len_en_d   = len_en_q;
        iv_d       = iv_q;
        dir_d      = dir_q;
        estep_d    = estep_q;
        scnt_d     = scnt_q;
        done_d     = done_q;
        vol_d      = vol_q;
        len_d      = len_q;
        on_d       = on_q;
        len_base   = len_q;
        base       = '0;

        env_tick  = (env_cnt_q == EW'(ENV_PERIOD - 1));
        len_tick  = (len_cnt_q == LW'(LEN_PERIOD - 1));
        env_cnt_d = env_tick ? '0 : env_cnt_q + 1'b1;
        len_cnt_d = len_tick ? '0 : len_cnt_q + 1'b1;

        fb      = lfsr_q[0] ^ lfsr_q[1];
        lfsr_nx = {fb, lfsr_q[LFSR_W-1:1]};
        if (short_q)
            lfsr_nx[SHORT_W-1] = fb;

        if (on_q && !freeze_q) begin
            if (freq_cnt_q == period_q - DIV_W'(1)) begin
                freq_cnt_d = '0;
                lfsr_d     = lfsr_nx;
            end else begin
                freq_cnt_d = freq_cnt_q + DIV_W'(1);
            end
        end

        // Volume saturation stops the envelope rather than wrapping
        if (env_tick && estep_q != 3'd0 && !done_q && on_q) begin
            if (scnt_q + 3'd1 == estep_q) begin
                scnt_d = '0;
                if (dir_q) begin
                    if (vol_q == 4'hF) done_d = 1'b1;
                    else               vol_d  = vol_q + 4'd1;
                end else begin
                    if (vol_q == 4'h0) done_d = 1'b1;
                    else               vol_d  = vol_q - 4'd1;
                end
            end else begin
                scnt_d = scnt_q + 3'd1;
            end
        end

        if (len_tick && len_en_q && len_q != '0) begin
            len_d = len_q - 1'b1;
            if (len_q == (LEN_W+1)'(1))
                on_d = 1'b0;
        end

        if (bus.wr_len) begin
            len_d    = LEN_MAX - {1'b0, bus.len_val};
            len_base = len_d;
        end

        if (bus.wr_env) begin
            iv_d    = bus.init_vol;
            dir_d   = bus.env_dir;
            estep_d = bus.env_step;
            if (bus.init_vol == 4'd0 && !bus.env_dir)
                on_d = 1'b0;
        end

        if (bus.wr_ctl) begin
            base     = (bus.div_ratio == 3'd0) ? DIV_W'(8)
                                               : DIV_W'(bus.div_ratio) << 4;
            period_d = base << bus.shift;
            freeze_d = (bus.shift >= 4'd14);
            short_d  = bus.short_mode;
            len_en_d = bus.len_en;
        end

        // Trigger restarts the voice; it overrides any same-cycle tick
        if (bus.wr_ctl && bus.trigger) begin
            lfsr_d     = '1;
            freq_cnt_d = '0;
            vol_d      = iv_d;
            scnt_d     = '0;
            done_d     = 1'b0;
            len_d      = (len_base == '0) ? LEN_MAX : len_base;
            on_d       = (iv_d != 4'd0) || dir_d;
        end
    end

    // Output sample derived from current state, registered once
    always_comb begin
        mag   = {{(OUT_W-4){1'b0}}, vol_q};
        smp_d = '0;
        if (on_q)
            smp_d = lfsr_q[0] ? (~mag + 1'b1) : mag;
    end

    // State registers with synchronous clear on reset or master disable
    always_ff @(posedge clk) begin
        if (clr) begin
            env_cnt_q  <= '0;
            len_cnt_q  <= '0;
            lfsr_q     <= '0;
            freq_cnt_q <= '0;
            period_q   <= '0;
            freeze_q   <= 1'b0;
            short_q    <= 1'b0;
            len_en_q   <= 1'b0;
            iv_q       <= '0;
            dir_q      <= 1'b0;
            estep_q    <= '0;
            scnt_q     <= '0;
            done_q     <= 1'b0;
            vol_q      <= '0;
            len_q      <= '0;
            on_q       <= 1'b0;
            smp_q      <= '0;
        end else begin
            env_cnt_q  <= env_cnt_d;
            len_cnt_q  <= len_cnt_d;
            lfsr_q     <= lfsr_d;
            freq_cnt_q <= freq_cnt_d;
            period_q   <= period_d;
            freeze_q   <= freeze_d;
            short_q    <= short_d;
            len_en_q   <= len_en_d;
            iv_q       <= iv_d;
            dir_q      <= dir_d;
            estep_q    <= estep_d;
            scnt_q     <= scnt_d;
            done_q     <= done_d;
            vol_q      <= vol_d;
            len_q      <= len_d;
            on_q       <= on_d;
            smp_q      <= smp_d;
        end
    end

    assign bus.sample_out = smp_q;
    assign bus.ch_on      = on_q;
    assign bus.len_left   = len_q;
endmodule
